maze_solver_ctrl: RTL and testbench
===================================

MAZE_SOLVER_CTRL -- requirements
Module: maze_solver_ctrl

Interface
REQ-001 SHALL have no parameters; the maze is fixed at 16x16 cells, X = row and Y = column, start cell (0,0), goal cell (15,15).
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins a solve run when in IDLE, DONE or FAIL.
REQ-005 mem_dout  in  1  maze memory read data, combinational from RD/X/Y (0 = open, 1 = wall or visited).
REQ-006 RD  out  1  maze memory read enable.
REQ-007 WR  out  1  maze memory write enable (write lands on the next posedge).
REQ-008 Din  out  1  maze memory write data.
REQ-009 X, Y  out  4 each  maze memory cell address.
REQ-010 busy  out  1  high from start acceptance until DONE or FAIL is reached.
REQ-011 done  out  1  path found and fully played back; held until the next start.
REQ-012 fail  out  1  no path exists; held until the next start.
REQ-013 move_valid, move_dir  out  1, 2  path playback stream; move_dir 0 = right (Y+1), 1 = down (X+1), 2 = left (Y-1), 3 = up (X-1).
REQ-014 move_ready  in  1  consumer accepts a move when move_valid and move_ready are both high.

Function
REQ-015 States: IDLE, INIT, MARK, PROBE, BACK, PLAY, DONE, FAIL.
REQ-016 Internal direction stack: 256 x 2 bits; pointer sp is 9 bits; playback pointer rp is 9 bits; current cell (cx,cy); trial direction td (2 bits).
REQ-017 start outside IDLE/DONE/FAIL SHALL be ignored; accepting start clears done/fail, sets busy, and sets cx=cy=0, sp=0, td=0, next state INIT.
REQ-018 INIT (1 cycle): RD=1 at (0,0); mem_dout=1 -> FAIL, else -> MARK.
REQ-019 MARK (1 cycle): WR=1, Din=1, X/Y=(cx,cy), marking the cell visited; if (cx,cy)=(15,15) -> PLAY with rp=0, else -> PROBE with td=0.
REQ-020 PROBE (1 cycle per direction): neighbour of (cx,cy) in direction td; if it is out of bounds, RD=0 and treat as blocked; otherwise RD=1 with X/Y = neighbour and sample mem_dout in the same cycle.
REQ-021 PROBE open neighbour: push td at stack[sp], sp+1, move (cx,cy) to the neighbour, -> MARK.
REQ-022 PROBE blocked with td<3: td+1, stay in PROBE; blocked with td=3: -> BACK.
REQ-023 BACK (1 cycle): sp=0 -> FAIL; otherwise pop d=stack[sp-1], sp-1, move (cx,cy) one step opposite to d; d<3 -> PROBE with td=d+1; d=3 -> remain in BACK.
REQ-024 No memory access in BACK; RD=WR=0 in every state other than INIT, MARK and PROBE.
REQ-025 PLAY: move_valid=1, move_dir=stack[rp]; rp+1 on each handshake; on the handshake with rp=sp-1 -> DONE; move_dir SHALL be held stable while move_valid=1 and move_ready=0.
REQ-026 DONE sets done=1 and busy=0; FAIL sets fail=1 and busy=0; both return to IDLE behaviour for start acceptance.
REQ-027 Visited marks (1 written) are left in memory after the run; the caller reloads the maze before re-solving.
REQ-028 Stack overflow SHALL be impossible: each cell is pushed at most once and the path length is at most 255.
REQ-029 Unused outputs in any state: X=Y=0, Din=0, move_valid=0, move_dir=0.

Reset
REQ-030 rst_n low SHALL immediately force the state to IDLE, with busy=done=fail=0, RD=WR=Din=0, X=Y=0, move_valid=0, move_dir=0, sp=rp=0, and cx=cy=td=0.
REQ-031 Reset asserted mid-run SHALL abort the run with no further writes; memory contents written before reset remain.
REQ-032 After rst_n deasserts, the block SHALL ignore everything except start.

Verification
REQ-033 All-zero maze, start pulse, move_ready=1 -> 15 moves of dir 0 then 15 moves of dir 1 (30 handshakes), then done=1, fail=0, busy=0.
REQ-034 Cell (0,0)=1, start -> INIT reads (0,0), fail=1 two cycles after start, no WR pulse.
REQ-035 Goal enclosed: (14,15)=(15,14)=1, rest 0 -> fail=1; afterwards every reachable cell reads 1 and move_valid never rises.
REQ-036 All-zero maze with move_ready toggling 1-0 every cycle -> move_dir stable while stalled, 30 handshakes total, sequence identical to REQ-033.
REQ-037 Start pulsed again while busy=1 -> ignored, run result unchanged; rst_n pulsed low mid-PROBE -> all outputs 0 asynchronously, no WR afterwards until a new start.

Source files
------------

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver for a fixed 16x16 bit-per-cell maze memory.
// The move sequence that was found is replayed through a valid/ready stream.
module maze_solver_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       mem_dout,
   input  logic       move_ready,
   output logic       RD,
   output logic       WR,
   output logic       Din,
   output logic [3:0] X,
   output logic [3:0] Y,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic       move_valid,
   output logic [1:0] move_dir
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_MARK, S_PROBE, S_BACK, S_PLAY, S_DONE, S_FAIL
   } state_t;

   state_t     state_r, state_s;
   logic [3:0] cx_r, cy_r, cx_s, cy_s;
   logic [8:0] sp_r, rp_r, sp_s, rp_s;
   logic [1:0] td_r, td_s;
   logic       busy_r, done_r, fail_r, busy_s, done_s, fail_s;
   logic       push_s;
   logic [1:0] stack_r [0:255];

   logic [3:0] nx_s, ny_s;
   logic       oob_s;
   logic [8:0] sp_m1_s;
   logic [1:0] top_s;

   assign busy    = busy_r;
   assign done    = done_r;
   assign fail    = fail_r;
   assign sp_m1_s = sp_r - 9'd1;
   assign top_s   = stack_r[sp_m1_s[7:0]];

   // Neighbour of the current cell in the trial direction, with edge detection
   always_comb begin
      nx_s  = cx_r;
      ny_s  = cy_r;
      oob_s = 1'b0;
      case (td_r)
         2'd0: begin oob_s = (cy_r == 4'd15); ny_s = cy_r + 4'd1; end
         2'd1: begin oob_s = (cx_r == 4'd15); nx_s = cx_r + 4'd1; end
         2'd2: begin oob_s = (cy_r == 4'd0);  ny_s = cy_r - 4'd1; end
         2'd3: begin oob_s = (cx_r == 4'd0);  nx_s = cx_r - 4'd1; end
         default: begin oob_s = 1'b1; end
      endcase
   end

   // Next-state, datapath update and memory/playback output decode
   always_comb begin
      state_s    = state_r;
      cx_s       = cx_r;
      cy_s       = cy_r;
      sp_s       = sp_r;
      rp_s       = rp_r;
      td_s       = td_r;
      busy_s     = busy_r;
      done_s     = done_r;
      fail_s     = fail_r;
      push_s     = 1'b0;
      RD         = 1'b0;
      WR         = 1'b0;
      Din        = 1'b0;
      X          = 4'd0;
      Y          = 4'd0;
      move_valid = 1'b0;
      move_dir   = 2'd0;
      case (state_r)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_s = S_INIT;
               busy_s  = 1'b1;
               done_s  = 1'b0;
               fail_s  = 1'b0;
               cx_s    = 4'd0;
               cy_s    = 4'd0;
               sp_s    = 9'd0;
               rp_s    = 9'd0;
               td_s    = 2'd0;
            end else begin
               state_s = state_r;
            end
         end
         S_INIT: begin
            RD = 1'b1;
            if (mem_dout) begin
               state_s = S_FAIL;
               fail_s  = 1'b1;
               busy_s  = 1'b0;
            end else begin
               state_s = S_MARK;
            end
         end
         S_MARK: begin
            WR  = 1'b1;
            Din = 1'b1;
            X   = cx_r;
            Y   = cy_r;
            if ((cx_r == 4'd15) && (cy_r == 4'd15)) begin
               state_s = S_PLAY;
               rp_s    = 9'd0;
            end else begin
               state_s = S_PROBE;
               td_s    = 2'd0;
            end
         end
         S_PROBE: begin
            if (!oob_s) begin
               RD = 1'b1;
               X  = nx_s;
               Y  = ny_s;
            end else begin
               RD = 1'b0;
            end
            if (!oob_s && !mem_dout) begin
               push_s  = 1'b1;
               sp_s    = sp_r + 9'd1;
               cx_s    = nx_s;
               cy_s    = ny_s;
               state_s = S_MARK;
            end else if (td_r != 2'd3) begin
               td_s = td_r + 2'd1;
            end else begin
               state_s = S_BACK;
            end
         end
         S_BACK: begin
            if (sp_r == 9'd0) begin
               state_s = S_FAIL;
               fail_s  = 1'b1;
               busy_s  = 1'b0;
            end else begin
               sp_s = sp_m1_s;
               case (top_s)
                  2'd0:    cy_s = cy_r - 4'd1;
                  2'd1:    cx_s = cx_r - 4'd1;
                  2'd2:    cy_s = cy_r + 4'd1;
                  2'd3:    cx_s = cx_r + 4'd1;
                  default: cx_s = cx_r;
               endcase
               // A fully exhausted direction 3 means this cell is also a dead end
               if (top_s != 2'd3) begin
                  state_s = S_PROBE;
                  td_s    = top_s + 2'd1;
               end else begin
                  state_s = S_BACK;
               end
            end
         end
         S_PLAY: begin
            move_valid = 1'b1;
            move_dir   = stack_r[rp_r[7:0]];
            if (move_ready) begin
               rp_s = rp_r + 9'd1;
               if (rp_r == sp_m1_s) begin
                  state_s = S_DONE;
                  done_s  = 1'b1;
                  busy_s  = 1'b0;
               end else begin
                  state_s = S_PLAY;
               end
            end else begin
               rp_s = rp_r;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Control and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
         cx_r    <= 4'd0;
         cy_r    <= 4'd0;
         sp_r    <= 9'd0;
         rp_r    <= 9'd0;
         td_r    <= 2'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         fail_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cx_r    <= cx_s;
         cy_r    <= cy_s;
         sp_r    <= sp_s;
         rp_r    <= rp_s;
         td_r    <= td_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         fail_r  <= fail_s;
      end
   end

   // Direction stack; entries above sp are never read so they need no reset
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_r[sp_r[7:0]] <= td_r;
      end
   end

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Directed bench for maze_solver_ctrl with a behavioural maze memory and a move scoreboard.
module tb_maze_solver_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       mem_dout;
   logic       move_ready = 1'b0;
   logic       RD, WR, Din;
   logic [3:0] X, Y;
   logic       busy, done, fail, move_valid;
   logic [1:0] move_dir;

   int n_checks = 0;
   int n_fail = 0;

   logic       mem [0:255];
   logic [1:0] exp_q [$];
   int         hs_count = 0;
   int         wr_count = 0;
   int         mv_rise = 0;
   logic       prev_stall = 1'b0;
   logic       prev_mv = 1'b0;
   logic [1:0] prev_dir = 2'd0;
   bit         toggle_ready = 1'b0;

   maze_solver_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mem_dout(mem_dout),
      .move_ready(move_ready), .RD(RD), .WR(WR), .Din(Din), .X(X), .Y(Y),
      .busy(busy), .done(done), .fail(fail), .move_valid(move_valid),
      .move_dir(move_dir)
   );

   always #5 clk = ~clk;

   assign mem_dout = RD ? mem[{X, Y}] : 1'b0;

   always @(posedge clk) begin
      if (WR) mem[{X, Y}] <= Din;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: scoreboard pops on handshakes, stall stability, write and valid-rise counts
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
         prev_mv    <= 1'b0;
      end else begin
         if (WR) wr_count <= wr_count + 1;
         if (move_valid && !prev_mv) mv_rise <= mv_rise + 1;
         if (prev_stall) begin
            check("stall_valid", {31'd0, move_valid}, 32'd1);
            check("stall_dir", {30'd0, move_dir}, {30'd0, prev_dir});
         end
         if (move_valid && move_ready) begin
            hs_count <= hs_count + 1;
            if (exp_q.size() == 0) begin
               check("queue_underflow", 32'd1, 32'd0);
            end else begin
               check("move_dir", {30'd0, move_dir}, {30'd0, exp_q.pop_front()});
            end
         end
         prev_stall <= move_valid && !move_ready;
         prev_mv    <= move_valid;
         prev_dir   <= move_dir;
      end
   end

   task automatic load_maze(input int w0, input int w1);
      for (int i = 0; i < 256; i++) mem[i] = 1'b0;
      if (w0 >= 0) mem[w0] = 1'b1;
      if (w1 >= 0) mem[w1] = 1'b1;
   endtask

   task automatic push_straight_path();
      for (int i = 0; i < 15; i++) exp_q.push_back(2'd0);
      for (int i = 0; i < 15; i++) exp_q.push_back(2'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_until_end(input int budget, input string tag);
      bit ended = 1'b0;
      for (int c = 0; c < budget && !ended; c++) begin
         @(posedge clk); #1;
         if (toggle_ready) move_ready = ~move_ready;
         if (done || fail) ended = 1'b1;
      end
      if (!ended) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      int hs0, wr0, mv0, ones;
      bit hit;
      load_maze(-1, -1);
      #2;
      check("reset_outputs", {15'd0, busy, done, fail, RD, WR, Din, X, Y, move_valid, move_dir}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_after_reset", {28'd0, busy, done, fail, WR}, 32'd0);

      // All-open maze, always ready, with a redundant start mid-run
      move_ready = 1'b1;
      push_straight_path();
      hs0 = hs_count;
      pulse_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      repeat (20) @(posedge clk);
      #1;
      check("busy_mid_run", {31'd0, busy}, 32'd1);
      pulse_start();
      run_until_end(3000, "open");
      check("open_done", {31'd0, done}, 32'd1);
      check("open_fail", {31'd0, fail}, 32'd0);
      check("open_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); #1;
      check("open_handshakes", hs_count - hs0, 32'd30);
      check("open_queue_empty", exp_q.size(), 32'd0);

      // Same maze replayed with move_ready toggling every cycle
      load_maze(-1, -1);
      push_straight_path();
      hs0 = hs_count;
      toggle_ready = 1'b1;
      pulse_start();
      run_until_end(4000, "toggle");
      toggle_ready = 1'b0;
      move_ready = 1'b1;
      check("toggle_done", {30'd0, done, fail}, 32'd2);
      @(negedge clk); #1;
      check("toggle_handshakes", hs_count - hs0, 32'd30);
      check("toggle_queue_empty", exp_q.size(), 32'd0);

      // Blocked start cell
      load_maze(0, -1);
      wr0 = wr_count;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("init_read", {23'd0, RD, X, Y}, {23'd0, 1'b1, 4'd0, 4'd0});
      check("init_flags", {29'd0, busy, done, fail}, 32'd4);
      @(posedge clk); #1;
      check("blocked_flags", {29'd0, busy, done, fail}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("blocked_no_write", wr_count - wr0, 32'd0);

      // Goal walled off: exhaustive search must fail without any playback
      load_maze(14 * 16 + 15, 15 * 16 + 14);
      mv0 = mv_rise;
      pulse_start();
      run_until_end(20000, "enclosed");
      check("enclosed_flags", {29'd0, busy, done, fail}, 32'd1);
      check("enclosed_no_valid", mv_rise - mv0, 32'd0);
      ones = 0;
      for (int i = 0; i < 256; i++) ones += (mem[i] === 1'b1) ? 1 : 0;
      check("enclosed_marked", ones, 32'd255);
      check("enclosed_goal_open", {31'd0, mem[255]}, 32'd0);

      // Reset asserted while probing
      load_maze(-1, -1);
      pulse_start();
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (RD && ({X, Y} != 8'd0)) hit = 1'b1;
         else begin @(posedge clk); #1; end
      end
      check("probe_seen", {31'd0, hit}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", {15'd0, busy, done, fail, RD, WR, Din, X, Y, move_valid, move_dir}, 32'd0);
      wr0 = wr_count;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_reset_no_write", wr_count - wr0, 32'd0);
      check("post_reset_idle", {29'd0, busy, done, fail}, 32'd0);
      check("start_cell_marked", {31'd0, mem[0]}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
